// File: rtl/mvm_pkg.sv
// mvm_pkg -- shared defaults and index-width helper for the MVM row path (rev 1.0)
`default_nettype none

package mvm_pkg;

  localparam int DEF_IWIDTH     = 32;
  localparam int DEF_OWIDTH     = 32;
  localparam int DEF_NUM_CHUNKS = 4;
  localparam int DEF_NUM_ROWS   = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Never returns zero, so a count of one still yields a legal vector width
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mvm_result_fifo.sv
// mvm_result_fifo -- synchronous result FIFO; push is accepted when full if a pop
// happens in the same cycle (rev 1.0)
`default_nettype none

module mvm_result_fifo
  import mvm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = idx_bits(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);

  // Gated so the read port shows zero rather than stale storage when empty
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mvm_row_accumulator.sv
// mvm_row_accumulator -- sums NUM_CHUNKS signed partials per matrix row and queues
// (sum, row index) for downstream (rev 1.0)
`default_nettype none

module mvm_row_accumulator
  import mvm_pkg::*;
#(
  parameter int IWIDTH     = DEF_IWIDTH,
  parameter int OWIDTH     = DEF_OWIDTH,
  parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          ivalid,
  input  logic [IWIDTH-1:0]             idata,
  output logic                          ovalid,
  input  logic                          oready,
  output logic [OWIDTH-1:0]             odata,
  output logic [idx_bits(NUM_ROWS)-1:0] orow,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int RW = idx_bits(NUM_ROWS);
  localparam int CW = idx_bits(NUM_CHUNKS);
  localparam int FW = OWIDTH + RW;

  logic signed [OWIDTH-1:0] acc;
  logic signed [OWIDTH-1:0] ext;
  logic signed [OWIDTH-1:0] sum;
  logic [CW-1:0]            chunk_cnt;
  logic [RW-1:0]            row_cnt;
  logic                     last_chunk;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [FW-1:0]            rdata;

  assign ext        = OWIDTH'($signed(idata));
  assign last_chunk = (chunk_cnt == CW'(NUM_CHUNKS-1));
  // Chunk 0 loads rather than adds, so no explicit accumulator clear is needed between rows
  assign sum        = (chunk_cnt == '0) ? ext : acc + ext;
  assign push       = ivalid && !clear && last_chunk;
  assign pop        = !empty && oready;

  assign ovalid        = !empty;
  assign {odata, orow} = rdata;

  mvm_result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata ({sum, row_cnt}),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      chunk_cnt  <= '0;
      row_cnt    <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      chunk_cnt  <= '0;
      row_cnt    <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && (orow == RW'(NUM_ROWS-1));
      if (push && full && !pop) overflow <= 1'b1;
      if (ivalid) begin
        acc <= sum;
        if (last_chunk) begin
          chunk_cnt <= '0;
          row_cnt   <= (row_cnt == RW'(NUM_ROWS-1)) ? '0 : row_cnt + RW'(1);
        end else begin
          chunk_cnt <= chunk_cnt + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
